// File: rtl/cpu_pkg.sv
// cpu_pkg: shared flag indices, flag width and CCR reset value
package cpu_pkg;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;
  localparam int FLAGS_W = 4;
  localparam logic [FLAGS_W-1:0] CCR_RST = 4'b0000;
endpackage

// File: rtl/ccr_shadow_stack.sv
// ccr_shadow_stack: flag LIFO (push/pop/din -> dout top, depth, full, empty); push+pop keeps the stack, full push and empty pop are ignored
module ccr_shadow_stack
  import cpu_pkg::*;
#(
  parameter int SHADOW_DEPTH = 2,
  parameter int DEPTH_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [FLAGS_W-1:0] din,
  output logic [FLAGS_W-1:0] dout,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty
);
  logic [FLAGS_W-1:0] mem [2**DEPTH_W];
  always_comb begin
    full = depth == DEPTH_W'(SHADOW_DEPTH);
    empty = depth == '0;
    dout = mem[depth - DEPTH_W'(1)];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
      for (int i = 0; i < 2**DEPTH_W; i++) mem[i] <= CCR_RST;
    end else if (push && !pop && !full) begin
      mem[depth] <= din;
      depth <= depth + DEPTH_W'(1);
    end else if (pop && !push && !empty) begin
      depth <= depth - DEPTH_W'(1);
    end
  end
endmodule

// File: rtl/ccr_unit.sv
// ccr_unit: condition code register (flag enables, alu_flags, jump clears, int_save/rti_restore -> flags_out, shadow_depth, sticky ovf_err/unf_err)
module ccr_unit
  import cpu_pkg::*;
#(
  parameter int SHADOW_DEPTH = 2,
  parameter int DEPTH_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               z_en,
  input  logic               n_en,
  input  logic               c_en,
  input  logic               v_en,
  input  logic [FLAGS_W-1:0] alu_flags,
  input  logic               jz_taken,
  input  logic               jn_taken,
  input  logic               jc_taken,
  input  logic               int_save,
  input  logic               rti_restore,
  output logic [FLAGS_W-1:0] flags_out,
  output logic [DEPTH_W-1:0] shadow_depth,
  output logic               ovf_err,
  output logic               unf_err
);
  logic [FLAGS_W-1:0] en, clr, upd, top;
  logic full, empty;
  always_comb begin
    en = {v_en, c_en, n_en, z_en};
    clr = '0;
    clr[FLAG_Z] = jz_taken;
    clr[FLAG_N] = jn_taken;
    clr[FLAG_C] = jc_taken;
    upd = ((en & alu_flags) | (~en & flags_out)) & ~clr;
  end
  ccr_shadow_stack #(.SHADOW_DEPTH(SHADOW_DEPTH), .DEPTH_W(DEPTH_W)) u_stack (
    .clk(clk),
    .rst(rst),
    .push(int_save),
    .pop(rti_restore),
    .din(upd),
    .dout(top),
    .depth(shadow_depth),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_out <= CCR_RST;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      flags_out <= rti_restore ? (empty ? CCR_RST : top) : upd;
      unf_err <= unf_err | (rti_restore & empty);
      ovf_err <= ovf_err | (int_save & ~rti_restore & full);
    end
  end
endmodule

// File: tb/tb_ccr_unit.sv
// tb_ccr_unit: directed self-checking bench for ccr_unit
module tb_ccr_unit;
  logic clk = 0, rst = 0;
  logic z_en = 0, n_en = 0, c_en = 0, v_en = 0;
  logic [3:0] alu_flags = 0;
  logic jz_taken = 0, jn_taken = 0, jc_taken = 0, int_save = 0, rti_restore = 0;
  logic [3:0] flags_out;
  logic [1:0] shadow_depth;
  logic ovf_err, unf_err;
  int total = 0, bad = 0;

  ccr_unit dut (
    .clk(clk), .rst(rst), .z_en(z_en), .n_en(n_en), .c_en(c_en), .v_en(v_en),
    .alu_flags(alu_flags), .jz_taken(jz_taken), .jn_taken(jn_taken), .jc_taken(jc_taken),
    .int_save(int_save), .rti_restore(rti_restore), .flags_out(flags_out),
    .shadow_depth(shadow_depth), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst = 0; {v_en, c_en, n_en, z_en} = 0; alu_flags = 0;
    {jz_taken, jn_taken, jc_taken, int_save, rti_restore} = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic set_flags(input logic [3:0] f);
    {v_en, c_en, n_en, z_en} = 4'b1111; alu_flags = f; tick();
  endtask

  task automatic do_reset();
    rst = 1; tick();
  endtask

  task automatic test_reset();
    set_flags(4'b1111);
    do_reset();
    total++; if (flags_out !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", flags_out); end
    total++; if (shadow_depth !== 2'd0) begin bad++; $display("FAIL reset_depth got=%0d exp=0", shadow_depth); end
    total++; if ({ovf_err, unf_err} !== 2'b00) begin bad++; $display("FAIL reset_err got=%b exp=00", {ovf_err, unf_err}); end
  endtask

  task automatic test_update();
    set_flags(4'b1010);
    total++; if (flags_out !== 4'b1010) begin bad++; $display("FAIL upd_all got=%b exp=1010", flags_out); end
    z_en = 1; alu_flags = 4'b0001; tick();
    total++; if (flags_out !== 4'b1011) begin bad++; $display("FAIL upd_z_only got=%b exp=1011", flags_out); end
    alu_flags = 4'b0100; tick();
    total++; if (flags_out !== 4'b1011) begin bad++; $display("FAIL upd_no_en got=%b exp=1011", flags_out); end
    n_en = 1; v_en = 1; alu_flags = 4'b0110; tick();
    total++; if (flags_out !== 4'b0011) begin bad++; $display("FAIL upd_nv got=%b exp=0011", flags_out); end
  endtask

  task automatic test_jump_clear();
    set_flags(4'b1111);
    jz_taken = 1; jc_taken = 1; z_en = 1; alu_flags = 4'b0001; tick();
    total++; if (flags_out !== 4'b1010) begin bad++; $display("FAIL jclr_zc got=%b exp=1010", flags_out); end
    set_flags(4'b1111);
    jn_taken = 1; tick();
    total++; if (flags_out !== 4'b1101) begin bad++; $display("FAIL jclr_n got=%b exp=1101", flags_out); end
  endtask

  task automatic test_save_restore();
    set_flags(4'b0110);
    int_save = 1; c_en = 1; alu_flags = 4'b0000; tick();
    total++; if (flags_out !== 4'b0010) begin bad++; $display("FAIL save_flags got=%b exp=0010", flags_out); end
    total++; if (shadow_depth !== 2'd1) begin bad++; $display("FAIL save_depth got=%0d exp=1", shadow_depth); end
    set_flags(4'b1111);
    total++; if (flags_out !== 4'b1111) begin bad++; $display("FAIL isr_flags got=%b exp=1111", flags_out); end
    rti_restore = 1; {v_en, c_en, n_en, z_en} = 4'b1111; alu_flags = 4'b1101; jz_taken = 1; tick();
    total++; if (flags_out !== 4'b0010) begin bad++; $display("FAIL rti_flags got=%b exp=0010", flags_out); end
    total++; if (shadow_depth !== 2'd0) begin bad++; $display("FAIL rti_depth got=%0d exp=0", shadow_depth); end
  endtask

  task automatic test_nested();
    do_reset();
    set_flags(4'b0001); int_save = 1; tick();
    set_flags(4'b0100); int_save = 1; tick();
    total++; if (shadow_depth !== 2'd2) begin bad++; $display("FAIL nest_depth2 got=%0d exp=2", shadow_depth); end
    total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL nest_no_ovf got=%b exp=0", ovf_err); end
    set_flags(4'b1000); int_save = 1; tick();
    total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL nest_ovf got=%b exp=1", ovf_err); end
    total++; if (shadow_depth !== 2'd2) begin bad++; $display("FAIL nest_ovf_depth got=%0d exp=2", shadow_depth); end
    total++; if (flags_out !== 4'b1000) begin bad++; $display("FAIL nest_ovf_flags got=%b exp=1000", flags_out); end
    rti_restore = 1; tick();
    total++; if (flags_out !== 4'b0100) begin bad++; $display("FAIL nest_rti1 got=%b exp=0100", flags_out); end
    rti_restore = 1; tick();
    total++; if (flags_out !== 4'b0001) begin bad++; $display("FAIL nest_rti2 got=%b exp=0001", flags_out); end
    total++; if (shadow_depth !== 2'd0) begin bad++; $display("FAIL nest_rti_depth got=%0d exp=0", shadow_depth); end
    total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL nest_ovf_sticky got=%b exp=1", ovf_err); end
    do_reset();
    total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL nest_ovf_rst got=%b exp=0", ovf_err); end
  endtask

  task automatic test_underflow();
    set_flags(4'b1111);
    rti_restore = 1; tick();
    total++; if (flags_out !== 4'b0000) begin bad++; $display("FAIL unf_flags got=%b exp=0000", flags_out); end
    total++; if (unf_err !== 1'b1) begin bad++; $display("FAIL unf_set got=%b exp=1", unf_err); end
    total++; if (shadow_depth !== 2'd0) begin bad++; $display("FAIL unf_depth got=%0d exp=0", shadow_depth); end
    for (int i = 0; i < 5; i++) tick();
    total++; if (unf_err !== 1'b1) begin bad++; $display("FAIL unf_sticky got=%b exp=1", unf_err); end
    do_reset();
    total++; if (unf_err !== 1'b0) begin bad++; $display("FAIL unf_rst got=%b exp=0", unf_err); end
  endtask

  task automatic test_tail_chain();
    set_flags(4'b0011); int_save = 1; tick();
    set_flags(4'b1100);
    int_save = 1; rti_restore = 1; {v_en, c_en, n_en, z_en} = 4'b1111; alu_flags = 4'b0101; tick();
    total++; if (flags_out !== 4'b0011) begin bad++; $display("FAIL tail_flags got=%b exp=0011", flags_out); end
    total++; if (shadow_depth !== 2'd1) begin bad++; $display("FAIL tail_depth got=%0d exp=1", shadow_depth); end
    set_flags(4'b1111); rti_restore = 1; tick();
    total++; if (flags_out !== 4'b0011) begin bad++; $display("FAIL tail_keep_top got=%b exp=0011", flags_out); end
    set_flags(4'b1111); int_save = 1; rti_restore = 1; tick();
    total++; if ({flags_out, unf_err} !== 5'b00001) begin bad++; $display("FAIL tail_empty got=%b_%b exp=0000_1", flags_out, unf_err); end
    total++; if (shadow_depth !== 2'd0) begin bad++; $display("FAIL tail_empty_depth got=%0d exp=0", shadow_depth); end
    do_reset();
    set_flags(4'b0110); int_save = 1; tick();
    int_save = 1; tick();
    total++; if (shadow_depth !== 2'd2) begin bad++; $display("FAIL rst_mid_pre got=%0d exp=2", shadow_depth); end
    rst = 1; int_save = 1; {v_en, c_en, n_en, z_en} = 4'b1111; alu_flags = 4'b1111; tick();
    total++; if ({shadow_depth, flags_out} !== 6'b000000) begin bad++; $display("FAIL rst_mid got=%0d_%b exp=0_0000", shadow_depth, flags_out); end
    rti_restore = 1; tick();
    total++; if ({flags_out, unf_err} !== 5'b00001) begin bad++; $display("FAIL rst_mid_rti got=%b_%b exp=0000_1", flags_out, unf_err); end
  endtask

  initial begin
    idle();
    test_reset();
    test_update();
    test_jump_clear();
    test_save_restore();
    test_nested();
    test_underflow();
    test_tail_chain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
